// File: rtl/row_scan_driver.sv
// Line-scan responder: fetches a board row, shifts it MSB-first to the
// column register, latches it, holds it lit, then pulses update.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   enable, lineNum scan request and row index from the control FSM
//   wr_en, wr_row,  board store write port
//   wr_data
//   sdata, shift_en serial column data (MSB first) and its qualifier
//   latch           column register transfer strobe
//   row_sel, row_on driven row index and row driver enable
//   update          one-cycle row-complete pulse
//   busy            high whenever not IDLE
module row_scan_driver #(
  parameter int ROW_W       = 8,
  parameter int ROWS        = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       lineNum,
  input  logic             wr_en,
  input  logic [2:0]       wr_row,
  input  logic [ROW_W-1:0] wr_data,
  output logic             sdata,
  output logic             shift_en,
  output logic             latch,
  output logic [2:0]       row_sel,
  output logic             row_on,
  output logic             update,
  output logic             busy
);

  localparam int CW = (ROW_W > 1) ? $clog2(ROW_W) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(ROW_W - 1);
  localparam logic [7:0]    HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH,
    HOLD,
    ACK
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cur_line_q, cur_line_d;
  logic [ROW_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [2:0]       row_sel_q, row_sel_d;
  logic [ROW_W-1:0] board_q [ROWS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cur_line_q <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      row_sel_q  <= '0;
    end else begin
      state_q    <= state_d;
      cur_line_q <= cur_line_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      row_sel_q  <= row_sel_d;
    end
  end

  // Board store. LOAD reads board_q before this edge's write lands,
  // so a same-edge write to the loading row shows up next scan.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROWS; i++) begin
        board_q[i] <= '0;
      end
    end else if (wr_en) begin
      board_q[wr_row] <= wr_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_line_d = cur_line_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    row_sel_d  = row_sel_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          cur_line_d = lineNum;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        shreg_d   = board_q[cur_line_q];
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bit_cnt_q == BIT_LAST) begin
          // row_sel moves with the latch pulse so both
          // column data and row index switch together.
          row_sel_d = cur_line_q;
          state_d   = LATCH;
        end
      end
      LATCH: begin
        hold_cnt_d = '0;
        state_d    = HOLD;
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign shift_en = (state_q == SHIFT);
  assign sdata    = shift_en & shreg_q[ROW_W-1];
  assign latch    = (state_q == LATCH);
  assign row_on   = (state_q == HOLD);
  assign update   = (state_q == ACK);
  assign busy     = (state_q != IDLE);
  assign row_sel  = row_sel_q;

endmodule

// File: tb/tb_row_scan_driver.sv
// Scoreboard bench for row_scan_driver: stimulus pushes expected
// output events, a negedge monitor pops and compares them.
module tb_row_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [2:0] lineNum;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       sdata;
  logic       shift_en;
  logic       latch;
  logic [2:0] row_sel;
  logic       row_on;
  logic       update;
  logic       busy;

  row_scan_driver dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .lineNum  (lineNum),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_data  (wr_data),
    .sdata    (sdata),
    .shift_en (shift_en),
    .latch    (latch),
    .row_sel  (row_sel),
    .row_on   (row_on),
    .update   (update),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_BIT, K_LAT, K_ON, K_UPD} kind_e;
  typedef struct {
    kind_e      k;
    logic [7:0] v;
    int         c;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic push(input kind_e k, input logic [7:0] v,
                      input int c);
    exp_t e;
    e.k = k;
    e.v = v;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic push_bits(input logic [2:0] line,
                           input logic [7:0] data);
    for (int i = 0; i < 8; i++) begin
      push(K_BIT, {7'b0, data[7-i]}, -1);
    end
    push(K_LAT, {5'b0, line}, -1);
  endtask

  // e0: cycle count just after the edge that samples enable.
  task automatic push_row(input logic [2:0] line,
                          input logic [7:0] data,
                          input int e0);
    push_bits(line, data);
    for (int i = 0; i < 4; i++) begin
      push(K_ON, {5'b0, line}, -1);
    end
    push(K_UPD, {5'b0, line}, e0 + 14);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t  e;
    int    n;
    kind_e ok;
    if (rst === 1'b1) begin
      n = int'(shift_en) + int'(latch) + int'(row_on) + int'(update);
      if (n > 1) chk("one_hot", n, 1);
      if (n != 0) begin
        if (shift_en)    ok = K_BIT;
        else if (latch)  ok = K_LAT;
        else if (row_on) ok = K_ON;
        else             ok = K_UPD;
        if (q.size() == 0) begin
          chk("unexpected_out", ok, 99);
        end else begin
          e = q.pop_front();
          chk("kind", ok, e.k);
          if (e.k == K_BIT) chk("sdata", sdata, e.v[0]);
          else              chk("row_sel", row_sel, e.v);
          if (e.k == K_UPD && e.c >= 0)
            chk("update_cycle", cyc, e.c);
        end
      end
    end
  end

  task automatic wr(input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_row  = r;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Returns at the negedge where update is seen.
  task automatic wait_update(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (update) seen = 1'b1;
    end
    chk({name, "_update_seen"}, seen, 1);
  endtask

  task automatic finish_row(input string name);
    wait_update(name);
    @(negedge clk);
    chk({name, "_busy_idle"}, busy, 0);
    chk({name, "_drain"}, q.size(), 0);
  endtask

  task automatic run_row(input logic [2:0] line,
                         input logic [7:0] data,
                         input string name);
    @(negedge clk);
    enable  = 1'b1;
    lineNum = line;
    push_row(line, data, cyc + 1);
    @(negedge clk);
    enable = 1'b0;
    finish_row(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst     = 1'b1;
    enable  = 1'b0;
    lineNum = 3'd0;
    wr_en   = 1'b0;
    wr_row  = 3'd0;
    wr_data = 8'h00;
    #2 rst  = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_row_on", row_on, 0);
    chk("rst_update", update, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_latch", latch, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_row_sel", row_sel, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: empty row 0
    run_row(3'd0, 8'h00, "t1");

    // 2: A5 on row 3
    wr(3'd3, 8'hA5);
    run_row(3'd3, 8'hA5, "t2");

    // 3: controller model, back-to-back scan of all rows
    for (int r = 0; r < 8; r++) wr(3'(r), 8'(1 << r));
    @(negedge clk);
    enable  = 1'b1;
    lineNum = 3'd0;
    begin
      int base;
      base = cyc + 1;
      for (int k = 0; k < 8; k++)
        push_row(3'(k), 8'(1 << k), base + 16 * k);
    end
    for (int k = 0; k < 8; k++) begin
      wait_update("t3");
      if (k < 7) lineNum = lineNum + 3'd1;
      else       enable  = 1'b0;
    end
    @(negedge clk);
    chk("t3_busy_idle", busy, 0);
    chk("t3_drain", q.size(), 0);

    // 4: lineNum change and enable drop mid-shift
    @(negedge clk);
    enable  = 1'b1;
    lineNum = 3'd2;
    push_row(3'd2, 8'h04, cyc + 1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    lineNum = 3'd5;
    enable  = 1'b0;
    finish_row("t4");
    chk("t4_row_sel_hold", row_sel, 2);

    // 5: write collides with LOAD of the same row
    wr(3'd4, 8'h0F);
    @(negedge clk);
    enable  = 1'b1;
    lineNum = 3'd4;
    push_row(3'd4, 8'h0F, cyc + 1);
    @(negedge clk);
    enable  = 1'b0;
    wr_en   = 1'b1;
    wr_row  = 3'd4;
    wr_data = 8'hF0;
    @(negedge clk);
    wr_en   = 1'b0;
    finish_row("t5a");
    run_row(3'd4, 8'hF0, "t5b");

    // 6: asynchronous reset in HOLD
    @(negedge clk);
    enable  = 1'b1;
    lineNum = 3'd1;
    push_bits(3'd1, 8'h02);
    push(K_ON, 8'd1, -1);
    @(negedge clk);
    enable = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (row_on) seen = 1'b1;
    end
    chk("t6_row_on_seen", seen, 1);
    #2 rst = 1'b0;
    #1;
    chk("t6_row_on", row_on, 0);
    chk("t6_busy", busy, 0);
    chk("t6_row_sel", row_sel, 0);
    chk("t6_update", update, 0);
    repeat (3) @(negedge clk);
    chk("t6_drain", q.size(), 0);
    rst = 1'b1;
    run_row(3'd1, 8'h00, "t6b");
    run_row(3'd3, 8'h00, "t6c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
